// File: rtl/tiny_processor.sv
// tiny_processor: 8-bit accumulator machine with a 16 x 8-bit instruction memory. This is the
// Tiny Tapeout user tile.
// The program is written byte by byte over ui_in in load mode. In run mode the core executes
// one instruction per clock. A latched output register drives a hex 7-segment display.
//
// Ports:
//   clk      rising-edge system clock
//   rst_n    synchronous reset, active-high despite the name; clears every state element
//   ena      tile enable; 0 freezes all state (reset still acts)
//   ui_in    program byte in load mode; operand source for IN
//   uo_out   [6:0] segments a..g (bit0 = a), [7] = OUT_REG[0]
//   uio_in   [4] load_mode, [5] wr_strobe, [6] run, [7] disp_hi; [3:0] unused
//   uio_out  [3:0] PC, [7:4] zero
//   uio_oe   constant 8'h0F
module tiny_processor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpAddi = 4'h2,
    OpSubi = 4'h3,
    OpAndi = 4'h4,
    OpOri  = 4'h5,
    OpXori = 4'h6,
    OpShl  = 4'h7,
    OpShr  = 4'h8,
    OpJmp  = 4'h9,
    OpJz   = 4'hA,
    OpJc   = 4'hB,
    OpLdh  = 4'hC,
    OpIn   = 4'hD,
    OpOut  = 4'hE,
    OpHlt  = 4'hF
  } opcode_e;

  logic       load_mode;
  logic       wr_strobe;
  logic       run;
  logic       disp_hi;
  logic       unused_uio;

  assign load_mode  = uio_in[4];
  assign wr_strobe  = uio_in[5];
  assign run        = uio_in[6];
  assign disp_hi    = uio_in[7];
  assign unused_uio = ^uio_in[3:0];

  logic [7:0] mem_q [16];
  logic [3:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic [7:0] out_q, out_d;
  logic       halt_q, halt_d;
  logic [3:0] laddr_q, laddr_d;
  logic       mem_we;

  logic [7:0] instr;
  opcode_e    op;
  logic [3:0] imm;
  logic [7:0] imm8;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [3:0] pc_inc;

  assign instr  = mem_q[pc_q];
  assign op     = opcode_e'(instr[7:4]);
  assign imm    = instr[3:0];
  assign imm8   = {4'h0, imm};
  assign sum9   = {1'b0, acc_q} + {1'b0, imm8};
  // Bit 8 of the 9-bit difference is set exactly when acc < imm (borrow).
  assign diff9  = {1'b0, acc_q} - {1'b0, imm8};
  assign pc_inc = pc_q + 4'd1;

  always_comb begin
    pc_d    = pc_q;
    acc_d   = acc_q;
    c_d     = c_q;
    out_d   = out_q;
    halt_d  = halt_q;
    laddr_d = laddr_q;
    mem_we  = 1'b0;
    if (load_mode) begin
      pc_d   = 4'd0;
      halt_d = 1'b0;
      if (wr_strobe) begin
        mem_we  = 1'b1;
        laddr_d = laddr_q + 4'd1;
      end
    end else begin
      laddr_d = 4'd0;
      if (run && !halt_q) begin
        pc_d = pc_inc;
        unique case (op)
          OpNop:  ;
          OpLdi:  acc_d = imm8;
          OpAddi: {c_d, acc_d} = sum9;
          OpSubi: {c_d, acc_d} = diff9;
          OpAndi: acc_d = acc_q & imm8;
          OpOri:  acc_d = acc_q | imm8;
          OpXori: acc_d = acc_q ^ imm8;
          OpShl:  {c_d, acc_d} = {acc_q, 1'b0};
          OpShr:  {acc_d, c_d} = {1'b0, acc_q};
          OpJmp:  pc_d = imm;
          OpJz:   if (acc_q == 8'h00) pc_d = imm;
          OpJc:   if (c_q) pc_d = imm;
          OpLdh:  acc_d = {imm, acc_q[3:0]};
          OpIn:   acc_d = ui_in;
          OpOut:  out_d = acc_q;
          OpHlt: begin
            halt_d = 1'b1;
            pc_d   = pc_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q    <= 4'd0;
      acc_q   <= 8'h00;
      c_q     <= 1'b0;
      out_q   <= 8'h00;
      halt_q  <= 1'b0;
      laddr_q <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (ena) begin
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      out_q   <= out_d;
      halt_q  <= halt_d;
      laddr_q <= laddr_d;
      if (mem_we) begin
        mem_q[laddr_q] <= ui_in;
      end
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg;

  assign nibble = disp_hi ? out_q[7:4] : out_q[3:0];

  always_comb begin
    seg = 7'h00;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign uo_out  = {out_q[0], seg};
  assign uio_out = {4'h0, pc_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tiny_processor.sv
module tb_tiny_processor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic load_mode, wr_strobe, run, disp_hi;
  assign uio_in = {disp_hi, run, wr_strobe, load_mode, 4'h0};

  int tests = 0;
  int failed = 0;

  tiny_processor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_mode = 1'b1;
    wr_strobe = 1'b1;
    ui_in     = b;
    tick(1);
    wr_strobe = 1'b0;
  endtask

  task automatic leave_load();
    load_mode = 1'b0;
    wr_strobe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00;
    load_mode = 1'b0; wr_strobe = 1'b0; run = 1'b0; disp_hi = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("reset_uo_out", uo_out, 8'h3F);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h0F);

    // LDI 5; ADDI 3; OUT; HLT
    load_byte(8'h15); load_byte(8'h23); load_byte(8'hE0); load_byte(8'hF0);
    leave_load();
    run = 1'b1;
    tick(6);
    check("add_uo_out", uo_out, 8'h7F);
    check("add_pc_halted", uio_out, 8'h03);
    tick(2);
    check("add_pc_still_halted", uio_out, 8'h03);
    run = 1'b0;

    // LDI F; LDH F; ADDI 1 (carry out); JC 5; HLT; OUT; HLT
    load_byte(8'h1F); load_byte(8'hCF); load_byte(8'h21); load_byte(8'hB5);
    load_byte(8'hF0); load_byte(8'hE0); load_byte(8'hF0);
    check("load_forces_pc0", uio_out, 8'h00);
    leave_load();
    run = 1'b1;
    tick(8);
    check("jc_uo_out", uo_out, 8'h3F);
    check("jc_pc", uio_out, 8'h06);
    run = 1'b0;

    // IN; OUT; HLT
    load_byte(8'hD0); load_byte(8'hE0); load_byte(8'hF0);
    leave_load();
    ui_in = 8'hA7;
    run = 1'b1;
    tick(4);
    check("in_disp_lo", uo_out, 8'h87);
    disp_hi = 1'b1;
    #1;
    check("in_disp_hi", uo_out, 8'hF7);
    disp_hi = 1'b0;
    check("in_pc", uio_out, 8'h02);
    run = 1'b0;

    // Re-enter load mode without writing: restarts the same program from PC 0.
    load_mode = 1'b1;
    tick(1);
    load_mode = 1'b0;
    check("reload_pc0", uio_out, 8'h00);
    ena = 1'b0;
    run = 1'b1;
    tick(3);
    check("ena0_pc_frozen", uio_out, 8'h00);
    check("ena0_uo_frozen", uo_out, 8'h87);
    ena = 1'b1;
    tick(1);
    check("step_pc", uio_out, 8'h01);
    run = 1'b0;
    tick(3);
    check("run0_pc_frozen", uio_out, 8'h01);
    check("run0_uo_frozen", uo_out, 8'h87);

    // Reset mid-run overrides the other inputs.
    run = 1'b1;
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    check("midrun_reset_uo", uo_out, 8'h3F);
    check("midrun_reset_pc", uio_out, 8'h00);
    tick(17);
    check("nop_wrap_pc", uio_out, 8'h01);
    run = 1'b0;

    // Seventeen writes wrap LADDR; an eighteenth byte lands in entry 1.
    for (int i = 0; i < 16; i++) load_byte(8'h11);
    load_byte(8'h12);
    load_byte(8'hE0);
    leave_load();
    run = 1'b1;
    tick(2);
    check("laddr_wrap_uo", uo_out, 8'h5B);
    check("laddr_wrap_pc", uio_out, 8'h02);
    run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tiny_processor.md
Name: tiny_processor

Overview:
- 8-bit accumulator processor with a 16-entry instruction memory, packaged as the Tiny Tapeout top-level user tile.
- The program is written over `ui_in` in load mode, then executed one instruction per clock in run mode.
- A latched output register drives a hex 7-segment display on `uo_out`. The PC is exported on `uio_out[3:0]`.

Parameters:
- none (fixed architecture: 16 x 8-bit instruction memory, 4-bit PC, 8-bit ACC)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset; synchronous and active-high (the port name is the codebase standard; the polarity is fixed as active-high)
- ena  input  1  tile enable; 0 freezes all state except reset
- ui_in  input  8  program byte in load mode; data source for the IN instruction
- uo_out  output  8  [6:0] 7-seg segments a..g (bit0 = a), active-high; [7] = OUT_REG[0] ("lsb")
- uio_in  input  8  [4] load_mode, [5] wr_strobe, [6] run, [7] disp_hi; [3:0] unused
- uio_out  output  8  [3:0] = PC; [7:4] = 0
- uio_oe  output  8  constant 8'h0F

Behaviour:
- State: MEM[0..15] (8 bits each), PC (4 bits), ACC (8 bits), C flag, OUT_REG (8 bits), HALT, LADDR (4 bits).
- Reset (rst_n=1 at clock edge) clears all state to 0. MEM is cleared to 0x00, which is NOP. Reset overrides ena and every other input.
- ena=0 (and no reset): no state changes.
- Load mode (`load_mode`=1):
  - PC forced to 0 and HALT cleared.
  - When `wr_strobe`=1: MEM[LADDR] <= ui_in, then LADDR <= LADDR+1, wrapping 15 to 0.
  - ACC, C and OUT_REG hold.
- LADDR is held at 0 whenever `load_mode`=0.
- Run: instructions execute only when ena=1, `load_mode`=0, `run`=1 and HALT=0.
  - Single-cycle: fetch MEM[PC], execute, and update PC on the same edge.
  - Default next PC = PC+1, wrapping 15 to 0.
- Instruction format: [7:4] opcode, [3:0] imm4. imm4 is zero-extended to 8 bits for ALU ops.
  - 0 NOP
  - 1 LDI: ACC = {0, imm}
  - 2 ADDI: {C, ACC} = ACC + imm (9-bit result)
  - 3 SUBI: ACC = ACC - imm; C = 1 if borrow (ACC < imm)
  - 4 ANDI, 5 ORI, 6 XORI: ACC op imm; C unchanged
  - 7 SHL: C = ACC[7]; ACC = ACC << 1
  - 8 SHR: C = ACC[0]; ACC = ACC >> 1 (logical)
  - 9 JMP: PC = imm
  - A JZ: PC = imm if ACC == 0, else PC+1
  - B JC: PC = imm if C == 1, else PC+1
  - C LDH: ACC[7:4] = imm; ACC[3:0] unchanged
  - D IN: ACC = ui_in
  - E OUT: OUT_REG = ACC
  - F HLT: HALT = 1; PC unchanged
- C is modified only by ADDI, SUBI, SHL and SHR.
- HALT is cleared only by reset or by entering load mode.
- Display (combinational):
  - nibble = `disp_hi` ? OUT_REG[7:4] : OUT_REG[3:0].
  - Standard hex segment codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - uo_out = {OUT_REG[0], seg[6:0]}.
- Reset output values: uo_out = 0x3F, uio_out = 0x00, uio_oe = 0x0F.
- Reset asserted mid-run: on the next edge PC = 0 and all state is 0, regardless of any other input.

Test Plan:
- Reset, then observe -> uo_out = 0x3F, uio_out = 0x00, uio_oe = 0x0F.
- Load 15 23 E0 F0, then run=1 for 6 cycles -> uo_out = 0x7F (ACC = 8); PC holds 3 while halted.
- Load 1F CF 21 B5 F0 E0 F0 (ACC = FF, +1 gives 00 with C=1, JC 5, OUT) -> uo_out = 0x3F; PC halts at 6.
- Load D0 E0 F0 with ui_in = 0xA7 at execution, then run:
  - `disp_hi`=0 -> uo_out = 0x87.
  - `disp_hi`=1 -> uo_out = 0xF7.
- Freeze and reset:
  - With the previous program, ena=0 or run=0 -> PC and outputs frozen.
  - Assert reset mid-run -> next cycle uo_out = 0x3F, PC = 0.
  - After that reset, run=1 for 17 cycles on the all-NOP memory -> PC = 1 (wrap).
- Load 17 bytes (16 x 0x11, then 0x12) -> entry 0 = 0x12 (LADDR wrap).
  - Then run 2 cycles followed by E0 at entry 1 -> ACC = 2.
